// File: rtl/galaga_lib.sv
// Shared playfield geometry and enemy-slot state type for the Galaga-style enemy blocks.
package galaga_lib;

  localparam int unsigned X_MIN   = 16;
  localparam int unsigned X_MAX   = 624;
  localparam int unsigned Y_MIN   = 16;
  localparam int unsigned Y_MAX   = 464;
  localparam int unsigned ESHIP_W = 16;
  localparam int unsigned ESHIP_H = 16;

  typedef enum logic [1:0] {ES_WAIT, ES_FLY, ES_EXPLODE, ES_DEAD} eship_state_t;

  function automatic int clamp_int(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/enemy_fleet_ctrl_if.sv
// Bundle of pixel, configuration, collision and status signals between the fleet and its users.
interface enemy_fleet_ctrl_if #(
  parameter int unsigned N_SHIPS     = 4,
  parameter int unsigned CW          = 10,
  parameter int unsigned SCHED_DEPTH = 16
);
  localparam int unsigned PixIdxW = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1;

  logic [CW-1:0]             DrawX;
  logic [CW-1:0]             DrawY;
  logic [N_SHIPS*CW-1:0]     init_x;
  logic [N_SHIPS*CW-1:0]     init_y;
  logic [SCHED_DEPTH*CW-1:0] sched_dx;
  logic [SCHED_DEPTH*CW-1:0] sched_dy;
  logic [N_SHIPS-1:0]        coll;
  logic [N_SHIPS*CW-1:0]     ship_x;
  logic [N_SHIPS*CW-1:0]     ship_y;
  logic [N_SHIPS-1:0]        alive;
  logic [N_SHIPS-1:0]        exploding;
  logic                      pix_on;
  logic [PixIdxW-1:0]        pix_idx;
  logic [CW-1:0]             pix_dx;
  logic [CW-1:0]             pix_dy;
  logic                      all_dead;

  modport master (
    output DrawX, DrawY, init_x, init_y, sched_dx, sched_dy, coll,
    input  ship_x, ship_y, alive, exploding, pix_on, pix_idx, pix_dx, pix_dy, all_dead
  );

  modport slave (
    input  DrawX, DrawY, init_x, init_y, sched_dx, sched_dy, coll,
    output ship_x, ship_y, alive, exploding, pix_on, pix_idx, pix_dx, pix_dy, all_dead
  );

endinterface

// File: rtl/enemy_ship_slot.sv
// One enemy slot: launch timing, schedule-driven flight with edge clamping, explosion, death.
module enemy_ship_slot
  import galaga_lib::*;
#(
  parameter int unsigned CW             = 10,
  parameter int unsigned SCHED_DEPTH    = 16,
  parameter int unsigned N_SHIPS        = 4,
  parameter int unsigned SLOT_IDX       = 0,
  parameter int unsigned LAUNCH_GAP     = 32,
  parameter int unsigned EXPLODE_FRAMES = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [15:0]               frame_ctr_i,
  input  logic [CW-1:0]             init_x_i,
  input  logic [CW-1:0]             init_y_i,
  input  logic [SCHED_DEPTH*CW-1:0] sched_dx_i,
  input  logic [SCHED_DEPTH*CW-1:0] sched_dy_i,
  input  logic                      coll_i,
  output logic [CW-1:0]             ship_x_o,
  output logic [CW-1:0]             ship_y_o,
  output eship_state_t              state_o
);

  localparam int unsigned IdxW = $clog2(SCHED_DEPTH);
  // Two extra bits keep the signed sum exact for any start position and step.
  localparam int unsigned SW   = CW + 2;
  localparam logic [15:0]     LaunchFrame = 16'(SLOT_IDX * LAUNCH_GAP);
  localparam logic [IdxW-1:0] StartIdx    =
      IdxW'((SLOT_IDX * (SCHED_DEPTH / N_SHIPS)) % SCHED_DEPTH);
  localparam logic [7:0]      EcLast      = 8'(EXPLODE_FRAMES - 1);
  localparam int              XLo = int'(X_MIN);
  localparam int              XHi = int'(X_MAX - ESHIP_W);
  localparam int              YLo = int'(Y_MIN);
  localparam int              YHi = int'(Y_MAX - ESHIP_H);

  eship_state_t    state_q, state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      ec_q, ec_d;

  logic signed [CW-1:0] raw_dx, raw_dy;
  logic signed [SW-1:0] nx, ny;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ES_WAIT;
      x_q     <= init_x_i;
      y_q     <= init_y_i;
      idx_q   <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ES_WAIT:    if (frame_ctr_i == LaunchFrame) state_d = ES_FLY;
      ES_FLY:     if (coll_i) state_d = ES_EXPLODE;
      ES_EXPLODE: if (ec_q == EcLast) state_d = ES_DEAD;
      ES_DEAD:    state_d = ES_DEAD;
      default:    state_d = ES_WAIT;
    endcase
  end

  always_comb begin
    raw_dx = sched_dx_i[idx_q*CW +: CW];
    raw_dy = sched_dy_i[idx_q*CW +: CW];
    nx     = $signed({2'b00, x_q}) + SW'(raw_dx);
    ny     = $signed({2'b00, y_q}) + SW'(raw_dy);
    x_d    = x_q;
    y_d    = y_q;
    idx_d  = idx_q;
    ec_d   = ec_q;
    unique case (state_q)
      ES_WAIT: begin
        if (frame_ctr_i == LaunchFrame) idx_d = StartIdx;
      end
      ES_FLY: begin
        if (coll_i) begin
          ec_d = '0;
        end else begin
          x_d   = CW'(clamp_int(int'(nx), XLo, XHi));
          y_d   = CW'(clamp_int(int'(ny), YLo, YHi));
          idx_d = idx_q + 1'b1;
        end
      end
      ES_EXPLODE: ec_d = ec_q + 8'd1;
      default: ;
    endcase
  end

  assign ship_x_o = x_q;
  assign ship_y_o = y_q;
  assign state_o  = state_q;

endmodule

// File: rtl/enemy_fleet_ctrl.sv
// N-slot enemy fleet: frame counter, per-slot controllers, priority pixel mux and wave status.
module enemy_fleet_ctrl
  import galaga_lib::*;
#(
  parameter int unsigned N_SHIPS        = 4,
  parameter int unsigned CW             = 10,
  parameter int unsigned SCHED_DEPTH    = 16,
  parameter int unsigned LAUNCH_GAP     = 32,
  parameter int unsigned EXPLODE_FRAMES = 8
) (
  input logic               frame_clk,
  input logic               Reset,
  enemy_fleet_ctrl_if.slave bus
);

  localparam int unsigned PixIdxW = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1;
  localparam logic [CW:0] ShipW   = (CW+1)'(ESHIP_W);
  localparam logic [CW:0] ShipH   = (CW+1)'(ESHIP_H);

  logic [15:0]           frame_ctr_q, frame_ctr_d;
  logic                  all_dead_q;
  logic [N_SHIPS*CW-1:0] ship_x_w, ship_y_w;
  logic [N_SHIPS-1:0]    alive_w, expl_w, dead_w, hit_w;
  eship_state_t          st_w [N_SHIPS];

  assign frame_ctr_d = (frame_ctr_q == 16'hFFFF) ? frame_ctr_q : frame_ctr_q + 16'd1;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      frame_ctr_q <= '0;
      all_dead_q  <= 1'b0;
    end else begin
      frame_ctr_q <= frame_ctr_d;
      all_dead_q  <= &dead_w;
    end
  end

  for (genvar i = 0; i < N_SHIPS; i++) begin : g_slot
    enemy_ship_slot #(
      .CW             (CW),
      .SCHED_DEPTH    (SCHED_DEPTH),
      .N_SHIPS        (N_SHIPS),
      .SLOT_IDX       (i),
      .LAUNCH_GAP     (LAUNCH_GAP),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_slot (
      .clk_i       (frame_clk),
      .rst_i       (Reset),
      .frame_ctr_i (frame_ctr_q),
      .init_x_i    (bus.init_x[i*CW +: CW]),
      .init_y_i    (bus.init_y[i*CW +: CW]),
      .sched_dx_i  (bus.sched_dx),
      .sched_dy_i  (bus.sched_dy),
      .coll_i      (bus.coll[i]),
      .ship_x_o    (ship_x_w[i*CW +: CW]),
      .ship_y_o    (ship_y_w[i*CW +: CW]),
      .state_o     (st_w[i])
    );

    assign alive_w[i] = (st_w[i] == ES_FLY);
    assign expl_w[i]  = (st_w[i] == ES_EXPLODE);
    assign dead_w[i]  = (st_w[i] == ES_DEAD);
    // Compare one bit wider so ship_x + width cannot wrap past the coordinate range.
    assign hit_w[i] = (alive_w[i] || expl_w[i]) &&
        ({1'b0, bus.DrawX} >= {1'b0, ship_x_w[i*CW +: CW]}) &&
        ({1'b0, bus.DrawX} <  ({1'b0, ship_x_w[i*CW +: CW]} + ShipW)) &&
        ({1'b0, bus.DrawY} >= {1'b0, ship_y_w[i*CW +: CW]}) &&
        ({1'b0, bus.DrawY} <  ({1'b0, ship_y_w[i*CW +: CW]} + ShipH));
  end

  // Scan from the top so the lowest-indexed hit overrides the rest.
  always_comb begin
    bus.pix_on  = 1'b0;
    bus.pix_idx = '0;
    bus.pix_dx  = '0;
    bus.pix_dy  = '0;
    for (int i = N_SHIPS - 1; i >= 0; i--) begin
      if (hit_w[i]) begin
        bus.pix_on  = 1'b1;
        bus.pix_idx = PixIdxW'(i);
        bus.pix_dx  = bus.DrawX - ship_x_w[i*CW +: CW];
        bus.pix_dy  = bus.DrawY - ship_y_w[i*CW +: CW];
      end
    end
  end

  assign bus.ship_x    = ship_x_w;
  assign bus.ship_y    = ship_y_w;
  assign bus.alive     = alive_w;
  assign bus.exploding = expl_w;
  assign bus.all_dead  = all_dead_q;

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Directed and randomized bench for enemy_fleet_ctrl against a frame-level fleet model.
module tb_enemy_fleet_ctrl;
  import galaga_lib::*;

  localparam int N = 4, CW = 10, D = 16, GAP = 32, EXF = 8;
  localparam int SW_WAIT = 0, SW_FLY = 1, SW_BOOM = 2, SW_DEAD = 3;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  enemy_fleet_ctrl_if #(.N_SHIPS(N), .CW(CW), .SCHED_DEPTH(D)) ifc ();

  enemy_fleet_ctrl #(
    .N_SHIPS        (N),
    .CW             (CW),
    .SCHED_DEPTH    (D),
    .LAUNCH_GAP     (GAP),
    .EXPLODE_FRAMES (EXF)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (ifc)
  );

  int checks = 0, errors = 0;
  int ix[N], iy[N], sdx[D], sdy[D];
  int m_st[N], m_x[N], m_y[N], m_idx[N], m_ec[N], m_fc;
  bit m_ad;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lim(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) begin
      ifc.init_x[i*CW +: CW] = ix[i][CW-1:0];
      ifc.init_y[i*CW +: CW] = iy[i][CW-1:0];
    end
    for (int k = 0; k < D; k++) begin
      ifc.sched_dx[k*CW +: CW] = sdx[k][CW-1:0];
      ifc.sched_dy[k*CW +: CW] = sdy[k][CW-1:0];
    end
  endtask

  // Advance the model by one frame using the inputs present before the edge.
  task automatic model_frame();
    bit every_dead;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = SW_WAIT; m_x[i] = ix[i]; m_y[i] = iy[i]; m_idx[i] = 0; m_ec[i] = 0;
      end
      m_fc = 0;
      m_ad = 0;
    end else begin
      every_dead = 1;
      for (int i = 0; i < N; i++) if (m_st[i] != SW_DEAD) every_dead = 0;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == SW_WAIT) begin
          if (m_fc == i * GAP) begin
            m_st[i] = SW_FLY;
            m_idx[i] = (i * (D / N)) % D;
          end
        end else if (m_st[i] == SW_FLY) begin
          if (ifc.coll[i]) begin
            m_st[i] = SW_BOOM;
            m_ec[i] = 0;
          end else begin
            m_x[i] = lim(m_x[i] + sdx[m_idx[i]], X_MIN, X_MAX - ESHIP_W);
            m_y[i] = lim(m_y[i] + sdy[m_idx[i]], Y_MIN, Y_MAX - ESHIP_H);
            m_idx[i] = (m_idx[i] + 1) % D;
          end
        end else if (m_st[i] == SW_BOOM) begin
          m_ec[i]++;
          if (m_ec[i] == EXF) m_st[i] = SW_DEAD;
        end
      end
      m_ad = every_dead;
      if (m_fc < 65535) m_fc++;
    end
  endtask

  task automatic check_all();
    logic [N*CW-1:0] ex, ey;
    logic [N-1:0] ea, ee;
    int px, py, hit_i;
    for (int i = 0; i < N; i++) begin
      ex[i*CW +: CW] = m_x[i][CW-1:0];
      ey[i*CW +: CW] = m_y[i][CW-1:0];
      ea[i] = (m_st[i] == SW_FLY);
      ee[i] = (m_st[i] == SW_BOOM);
    end
    chk("ship_x", ifc.ship_x, ex);
    chk("ship_y", ifc.ship_y, ey);
    chk("alive", ifc.alive, ea);
    chk("exploding", ifc.exploding, ee);
    chk("all_dead", ifc.all_dead, m_ad);
    px = ifc.DrawX; py = ifc.DrawY; hit_i = -1;
    for (int i = 0; i < N; i++)
      if (hit_i < 0 && (m_st[i] == SW_FLY || m_st[i] == SW_BOOM) &&
          px >= m_x[i] && px < m_x[i] + ESHIP_W && py >= m_y[i] && py < m_y[i] + ESHIP_H)
        hit_i = i;
    chk("pix_on", ifc.pix_on, hit_i >= 0);
    chk("pix_idx", ifc.pix_idx, (hit_i >= 0) ? hit_i : 0);
    chk("pix_dx", ifc.pix_dx, (hit_i >= 0) ? px - m_x[hit_i] : 0);
    chk("pix_dy", ifc.pix_dy, (hit_i >= 0) ? py - m_y[hit_i] : 0);
  endtask

  task automatic frame();
    model_frame();
    @(posedge frame_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive_cfg();
    Reset = 1'b1;
    frame();
    frame();
    chk("rst_alive", ifc.alive, 0);
    chk("rst_all_dead", ifc.all_dead, 0);
    Reset = 1'b0;
  endtask

  initial begin
    ifc.coll = '0; ifc.DrawX = '0; ifc.DrawY = '0;

    // Launch stagger and constant +3 drift.
    for (int i = 0; i < N; i++) begin ix[i] = 200 + 50 * i; iy[i] = 300; end
    ix[0] = 100; iy[0] = 100;
    for (int k = 0; k < D; k++) begin sdx[k] = 3; sdy[k] = 0; end
    do_reset();
    chk("rst_x0", ifc.ship_x[CW-1:0], 100);
    for (int t = 1; t <= 40; t++) begin
      frame();
      if (t == 1)  chk("t1_alive0", ifc.alive[0], 1);
      if (t == 1)  chk("t1_x0", ifc.ship_x[CW-1:0], 100);
      if (t == 20) chk("t2_x0", ifc.ship_x[CW-1:0], 157);
      if (t == 32) chk("t1_wait1", ifc.alive[1], 0);
      if (t == 33) chk("t1_alive1", ifc.alive[1], 1);
    end

    // Left-edge clamp with independent y motion.
    ix[0] = X_MIN + 2; iy[0] = 100;
    for (int k = 0; k < D; k++) begin sdx[k] = -5; sdy[k] = 2; end
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      frame();
      if (t == 2) chk("t3_x_clamp", ifc.ship_x[CW-1:0], X_MIN);
      if (t == 4) chk("t3_x_hold", ifc.ship_x[CW-1:0], X_MIN);
      if (t == 4) chk("t3_y", ifc.ship_y[CW-1:0], 106);
    end

    // Overlap priority, explosion length, second collision ignored.
    ix = '{112, 115, 400, 500}; iy = '{72, 75, 300, 300};
    for (int k = 0; k < D; k++) begin sdx[k] = 0; sdy[k] = 0; end
    ifc.DrawX = 10'd120; ifc.DrawY = 10'd80;
    do_reset();
    repeat (34) frame();
    chk("t5_idx0", ifc.pix_idx, 0);
    chk("t5_dx0", ifc.pix_dx, 8);
    ifc.coll = 4'b0001;
    frame();
    ifc.coll = '0;
    chk("t4_expl_start", ifc.exploding[0], 1);
    for (int k = 2; k <= EXF; k++) begin
      ifc.coll = (k == 3) ? 4'b0001 : 4'b0000;
      frame();
      chk("t4_expl_hold", ifc.exploding[0], 1);
      chk("t4_pos_frozen", ifc.ship_x[CW-1:0], 112);
    end
    ifc.coll = '0;
    frame();
    chk("t4_dead", ifc.exploding[0] | ifc.alive[0], 0);
    chk("t5_idx1", ifc.pix_idx, 1);
    chk("t5_dx1", ifc.pix_dx, 5);

    // Wave clear, then all_dead one frame later.
    repeat (60) frame();
    ifc.coll = 4'b1110;
    frame();
    ifc.coll = '0;
    repeat (EXF) frame();
    chk("t6_not_yet", ifc.all_dead, 0);
    frame();
    chk("t6_all_dead", ifc.all_dead, 1);

    // Reset in the middle of an explosion.
    do_reset();
    repeat (100) frame();
    ifc.coll = 4'b1111;
    frame();
    ifc.coll = '0;
    repeat (3) frame();
    Reset = 1'b1;
    frame();
    chk("t6_rst_expl", ifc.exploding, 0);
    chk("t6_rst_x", ifc.ship_x, {10'd500, 10'd400, 10'd115, 10'd112});
    Reset = 1'b0;

    // Randomized flight, collisions and pixel probes.
    for (int i = 0; i < N; i++) begin
      ix[i] = $urandom_range(X_MAX - ESHIP_W, X_MIN);
      iy[i] = $urandom_range(Y_MAX - ESHIP_H, Y_MIN);
    end
    for (int k = 0; k < D; k++) begin
      sdx[k] = int'($urandom_range(16, 0)) - 8;
      sdy[k] = int'($urandom_range(16, 0)) - 8;
    end
    do_reset();
    for (int t = 0; t < 400; t++) begin
      int j;
      j = $urandom_range(N - 1, 0);
      ifc.DrawX = 10'(m_x[j] + int'($urandom_range(20, 0)) - 2);
      ifc.DrawY = 10'(m_y[j] + int'($urandom_range(20, 0)) - 2);
      for (int i = 0; i < N; i++) ifc.coll[i] = ($urandom_range(59, 0) == 0);
      frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
